// File: rtl/mem_compare_pkg.sv
// Shared definitions for the mem_compare / mem_range_reader slice: default sizes and FSM state encoding.
package mem_compare_pkg;

  localparam int MC_WIDTH_DEFAULT     = 256;
  localparam int MC_MAX_DEPTH_DEFAULT = 320;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_DRAIN = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_t;

endpackage

// File: rtl/mem_range_reader.sv
// Walks an inclusive address range one word per cycle and tracks the 1-cycle sync SRAM read latency.
// Shared with mem_copy; the owning FSM decides when to load and when to run.
module mem_range_reader #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          run,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] addr,
  output logic          en,
  output logic          rd_valid,
  output logic          last,
  output logic          empty
);

  logic [AW-1:0] end_q;

  // The counter parks on end_q instead of wrapping, so last stays stable once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      end_q    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= run;
      if (load) begin
        addr  <= start_addr;
        end_q <= end_addr;
      end else if (run && !last) begin
        addr <= addr + AW'(1);
      end
    end
  end

  assign en    = run;
  assign last  = (addr == end_q);
  assign empty = (end_addr < start_addr);

endmodule

// File: rtl/mem_compare.sv
// Constant-time equality check of two SRAM regions; run time depends only on the address range.
// Optional observation ports (mismatch count, first mismatch address) under `MEM_COMPARE_DEBUG_EN.
module mem_compare
  import mem_compare_pkg::*;
#(
  parameter int WIDTH         = MC_WIDTH_DEFAULT,
  parameter int MAX_MEM_DEPTH = MC_MAX_DEPTH_DEFAULT,
  localparam int AW           = $clog2(MAX_MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_start_addr,
  input  logic [AW-1:0]    i_end_addr,
  output logic [AW-1:0]    o_mem_a_addr,
  output logic             o_mem_a_en,
  input  logic [WIDTH-1:0] i_mem_a,
  output logic [AW-1:0]    o_mem_b_addr,
  output logic             o_mem_b_en,
  input  logic [WIDTH-1:0] i_mem_b,
  output logic             o_equal,
  output logic             o_done
`ifdef MEM_COMPARE_DEBUG_EN
  ,
  output logic [AW:0]      o_mismatch_cnt,
  output logic [AW-1:0]    o_first_mismatch_addr
`endif
);

  mc_state_t     state, state_next;
  logic          load, run;
  logic [AW-1:0] rd_addr;
  logic          rd_en, rd_valid, rd_last, range_empty;
  logic          word_diff;
  logic          diff;
  logic          result_valid;

  mem_range_reader #(
    .AW(AW)
  ) u_reader (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (load),
    .run       (run),
    .start_addr(i_start_addr),
    .end_addr  (i_end_addr),
    .addr      (rd_addr),
    .en        (rd_en),
    .rd_valid  (rd_valid),
    .last      (rd_last),
    .empty     (range_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= MC_IDLE;
    else          state <= state_next;
  end

  // An empty range skips READ so no read enable is ever raised, but still drains for timing.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    run        = 1'b0;
    unique case (state)
      MC_IDLE: begin
        if (i_start) begin
          load       = 1'b1;
          state_next = range_empty ? MC_DRAIN : MC_READ;
        end
      end
      MC_READ: begin
        run = 1'b1;
        if (rd_last) state_next = MC_DRAIN;
      end
      MC_DRAIN: state_next = MC_DONE;
      MC_DONE:  state_next = MC_IDLE;
      default:  state_next = MC_IDLE;
    endcase
  end

  assign word_diff = |(i_mem_a ^ i_mem_b);

  // Every compared word is folded in unconditionally; no branch depends on the data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      diff         <= 1'b0;
      result_valid <= 1'b0;
    end else if (load) begin
      diff         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (rd_valid)          diff         <= diff | word_diff;
      if (state == MC_DRAIN) result_valid <= 1'b1;
    end
  end

  assign o_mem_a_addr = rd_addr;
  assign o_mem_b_addr = rd_addr;
  assign o_mem_a_en   = rd_en;
  assign o_mem_b_en   = rd_en;
  assign o_done       = (state == MC_DONE);
  assign o_equal      = result_valid & ~diff;

`ifdef MEM_COMPARE_DEBUG_EN
  logic [AW-1:0] cmp_addr;
  logic [AW:0]   mismatch_cnt;
  logic [AW-1:0] first_mismatch;

  // cmp_addr lags the issued address by one cycle so it lines up with the returning data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmp_addr       <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
    end else begin
      if (rd_en) cmp_addr <= rd_addr;
      if (load) begin
        mismatch_cnt   <= '0;
        first_mismatch <= '0;
      end else if (rd_valid && word_diff) begin
        mismatch_cnt <= mismatch_cnt + (AW+1)'(1);
        if (mismatch_cnt == '0) first_mismatch <= cmp_addr;
      end
    end
  end

  assign o_mismatch_cnt        = mismatch_cnt;
  assign o_first_mismatch_addr = first_mismatch;
`else
  // Observation ports are absent in this build; the compare path is identical.
`endif

endmodule

// File: tb/tb_mem_compare.sv
// Directed bench for mem_compare: bench-side SRAM models, address and result scoreboards, cycle-exact done timing.
module tb_mem_compare;

  localparam int WIDTH = 256;
  localparam int DEPTH = 320;
  localparam int AW    = $clog2(DEPTH);

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [AW-1:0]    i_start_addr = '0;
  logic [AW-1:0]    i_end_addr = '0;
  logic [AW-1:0]    o_mem_a_addr, o_mem_b_addr;
  logic             o_mem_a_en, o_mem_b_en;
  logic [WIDTH-1:0] i_mem_a, i_mem_b;
  logic             o_equal, o_done;
`ifdef MEM_COMPARE_DEBUG_EN
  logic [AW:0]      o_mismatch_cnt;
  logic [AW-1:0]    o_first_mismatch_addr;
`endif

  mem_compare #(
    .WIDTH(WIDTH),
    .MAX_MEM_DEPTH(DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_start_addr(i_start_addr),
    .i_end_addr  (i_end_addr),
    .o_mem_a_addr(o_mem_a_addr),
    .o_mem_a_en  (o_mem_a_en),
    .i_mem_a     (i_mem_a),
    .o_mem_b_addr(o_mem_b_addr),
    .o_mem_b_en  (o_mem_b_en),
    .i_mem_b     (i_mem_b),
    .o_equal     (o_equal),
    .o_done      (o_done)
`ifdef MEM_COMPARE_DEBUG_EN
    ,
    .o_mismatch_cnt       (o_mismatch_cnt),
    .o_first_mismatch_addr(o_first_mismatch_addr)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Sync SRAM models: data valid one cycle after addr/en.
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] rd_a = '0, rd_b = '0;

  always @(posedge i_clk) begin
    if (o_mem_a_en) rd_a <= (int'(o_mem_a_addr) < DEPTH) ? mem_a[o_mem_a_addr] : 'x;
    if (o_mem_b_en) rd_b <= (int'(o_mem_b_addr) < DEPTH) ? mem_b[o_mem_b_addr] : 'x;
  end
  assign i_mem_a = rd_a;
  assign i_mem_b = rd_b;

  typedef struct {
    int   cyc;
    logic eq;
    int   cnt;
    int   first;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   cmp_cnt = 0;
  int   fail_cnt = 0;
  int   edge_cnt = 0;
  int   start_edge = 0;
  logic last_eq = 1'b0;

  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  function automatic int cur_cycle();
    return edge_cnt - start_edge + 1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every read must match the next expected address, every done the next result.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_mem_a_en || o_mem_b_en) begin
        cmp_cnt++;
        assert (addr_q.size() > 0) else begin
          fail_cnt++;
          $error("[TB] FAIL spurious_read: observed addr=%0d expected no read", o_mem_a_addr);
        end
        if (addr_q.size() > 0) begin
          int ea;
          ea = addr_q.pop_front();
          check_output("a_en", 32'(o_mem_a_en), 32'd1);
          check_output("b_en", 32'(o_mem_b_en), 32'd1);
          check_output("a_addr", 32'(o_mem_a_addr), 32'(ea));
          check_output("b_addr", 32'(o_mem_b_addr), 32'(ea));
        end
      end
      if (o_done) begin
        cmp_cnt++;
        assert (exp_q.size() > 0) else begin
          fail_cnt++;
          $error("[TB] FAIL spurious_done: observed done at cycle %0d expected none", cur_cycle());
        end
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("done_cycle", 32'(cur_cycle()), 32'(e.cyc));
          check_output("equal", 32'(o_equal), 32'(e.eq));
`ifdef MEM_COMPARE_DEBUG_EN
          check_output("mismatch_cnt", 32'(o_mismatch_cnt), 32'(e.cnt));
          check_output("first_mismatch", 32'(o_first_mismatch_addr), 32'(e.first));
`endif
        end
      end
    end
  end

  task automatic apply_stimulus(input int sa, input int ea);
    exp_t e;
    @(negedge i_clk);
    e.eq = 1'b1; e.cnt = 0; e.first = 0;
    for (int a = sa; a <= ea; a++) begin
      addr_q.push_back(a);
      if (mem_a[a] !== mem_b[a]) begin
        if (e.cnt == 0) e.first = a;
        e.eq = 1'b0;
        e.cnt++;
      end
    end
    e.cyc = (ea >= sa) ? (ea - sa + 1) + 2 : 2;
    last_eq = e.eq;
    exp_q.push_back(e);
    i_start_addr = AW'(sa);
    i_end_addr   = AW'(ea);
    i_start      = 1'b1;
    start_edge   = edge_cnt + 1;
    @(negedge i_clk);
    i_start = 1'b0;
    check_output("equal_cleared_on_start", 32'(o_equal), 32'd0);
  endtask

  task automatic wait_until_cycle(input int c);
    int guard = 0;
    while (cur_cycle() != c && guard < 2000) begin
      @(negedge i_clk);
      guard++;
    end
    check_output("reached_cycle", 32'(cur_cycle()), 32'(c));
  endtask

  task automatic wait_done(input int budget);
    int guard = 0;
    while (exp_q.size() != 0 && guard < budget) begin
      @(negedge i_clk);
      guard++;
    end
    repeat (2) @(negedge i_clk);
    check_output("done_pending", 32'(exp_q.size()), 32'd0);
    check_output("reads_pending", 32'(addr_q.size()), 32'd0);
    check_output("equal_held_idle", 32'(o_equal), 32'(last_eq));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < WIDTH / 32; k++) mem_a[i][k*32 +: 32] = $urandom;
      mem_b[i] = mem_a[i];
    end

    // Reset state
    repeat (2) @(negedge i_clk);
    check_output("rst_a_en", 32'(o_mem_a_en), 32'd0);
    check_output("rst_b_en", 32'(o_mem_b_en), 32'd0);
    check_output("rst_addr", 32'(o_mem_a_addr), 32'd0);
    check_output("rst_done", 32'(o_done), 32'd0);
    check_output("rst_equal", 32'(o_equal), 32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    $display("[TB] test 1: full range, identical");
    apply_stimulus(0, 319);
    wait_done(400);

    $display("[TB] test 2: word 137 differs in bit 0");
    mem_b[137][0] = ~mem_b[137][0];
    apply_stimulus(0, 319);
    wait_done(400);
    mem_b[137] = mem_a[137];

    $display("[TB] test 3: first and last words corrupted, then identical");
    mem_b[0]   = ~mem_a[0];
    mem_b[319] = mem_a[319] ^ {1'b1, {(WIDTH-1){1'b0}}};
    apply_stimulus(0, 319);
    wait_done(400);
    mem_b[0]   = mem_a[0];
    mem_b[319] = mem_a[319];
    apply_stimulus(0, 319);
    wait_done(400);

    $display("[TB] test 4: single word and empty range");
    apply_stimulus(5, 5);
    wait_done(20);
    mem_b[12] = ~mem_a[12];
    apply_stimulus(10, 4);
    wait_done(20);
    apply_stimulus(12, 13);
    wait_done(20);
    mem_b[12] = mem_a[12];

    $display("[TB] test 5: reset mid-run");
    apply_stimulus(0, 319);
    wait_until_cycle(100);
    i_rst_n = 1'b0;
    #1;
    check_output("midrst_a_en", 32'(o_mem_a_en), 32'd0);
    check_output("midrst_b_en", 32'(o_mem_b_en), 32'd0);
    check_output("midrst_addr", 32'(o_mem_a_addr), 32'd0);
    check_output("midrst_done", 32'(o_done), 32'd0);
    check_output("midrst_equal", 32'(o_equal), 32'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    mem_b[200] = ~mem_a[200];
    apply_stimulus(0, 319);
    wait_done(400);
    mem_b[200] = mem_a[200];

    $display("[TB] test 6: start pulses while busy and during done");
    apply_stimulus(0, 319);
    wait_until_cycle(50);
    i_start_addr = AW'(7);
    i_end_addr   = AW'(9);
    i_start      = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_until_cycle(322);
    check_output("done_at_322", 32'(o_done), 32'd1);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    check_output("no_restart_en", 32'(o_mem_a_en), 32'd0);
    wait_done(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
